// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes and data-memory waits, with saturating perf counters and a timeout flag.
module pipeline_hazard_controller #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned MEM_TIMEOUT     = 64,
  parameter bit          FLUSH_ON_BRANCH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       dec_aa,
  input  logic [4:0]       dec_ab,
  input  logic             dec_uses_aa,
  input  logic             dec_uses_ab,
  input  logic             dec_br_taken,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_aw,
  input  logic             ex_reg_write,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             fd_write,
  output logic             fd_flush,
  output logic             de_write,
  output logic             de_bubble,
  output logic             em_write,
  output logic             mw_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_error
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {StRun, StStall, StWait} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             memwait, loaduse, br_flush;

  assign memwait  = mem_access && !mem_ready;
  // Register 31 is hard-wired zero, so it never carries a dependency.
  assign loaduse  = ex_mem_read && ex_reg_write && (ex_aw != 5'd31) &&
                    ((dec_uses_aa && (dec_aa == ex_aw)) || (dec_uses_ab && (dec_ab == ex_aw)));
  assign br_flush = dec_br_taken && FLUSH_ON_BRANCH;

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b1;
    fd_write  = 1'b1;
    de_write  = 1'b1;
    em_write  = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    mw_bubble = 1'b0;

    if (memwait) begin
      // Memory wait freezes everything from any state and drains a bubble into Wb.
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      de_write  = 1'b0;
      em_write  = 1'b0;
      mw_bubble = 1'b1;
      state_d   = StWait;
    end else begin
      unique case (state_q)
        StRun: begin
          if (loaduse) begin
            pc_write  = 1'b0;
            fd_write  = 1'b0;
            de_bubble = 1'b1;
            state_d   = StStall;
          end else begin
            fd_flush = br_flush;
          end
        end
        StStall: begin
          fd_flush = br_flush;
          state_d  = StRun;
        end
        StWait: begin
          // Release cycle: hazards are re-evaluated once back in RUN.
          state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end

    if (reset) begin
      pc_write  = 1'b0;
      fd_write  = 1'b0;
      de_write  = 1'b0;
      em_write  = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      mw_bubble = 1'b1;
    end
  end

  // Counts every cycle spent heading into or held in WAIT, saturating at the timeout.
  always_comb begin
    wait_cnt_d = '0;
    if (state_d == StWait) begin
      wait_cnt_d = (wait_cnt_q == TimeoutCnt) ? wait_cnt_q : wait_cnt_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      stall_count <= '0;
      flush_count <= '0;
      mem_error   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (!pc_write && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (fd_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if (wait_cnt_d == TimeoutCnt) begin
        mem_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed plan steps plus random traffic,
// checked against a cycle-level reference model with unbounded event tallies.
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] dec_aa, dec_ab, ex_aw;
  logic       dec_uses_aa, dec_uses_ab, dec_br_taken;
  logic       ex_mem_read, ex_reg_write, mem_access, mem_ready;

  // a: default build, b: no branch flush, c: 4-bit counters
  logic        a_pc, a_fd, a_fdf, a_de, a_deb, a_em, a_mwb, a_me;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_fd, b_fdf, b_de, b_deb, b_em, b_mwb, b_me;
  logic [15:0] b_sc, b_fc;
  logic        c_pc, c_fd, c_fdf, c_de, c_deb, c_em, c_mwb, c_me;
  logic [3:0]  c_sc, c_fc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_known, m_in_wait, m_stalled, m_err;
  int m_wc, m_stall_raw, m_flush_raw, m_flush_raw_nf;

  always #5 clk = ~clk;

  pipeline_hazard_controller u_a (
    .clk(clk), .reset(reset), .dec_aa(dec_aa), .dec_ab(dec_ab), .dec_uses_aa(dec_uses_aa),
    .dec_uses_ab(dec_uses_ab), .dec_br_taken(dec_br_taken), .ex_mem_read(ex_mem_read),
    .ex_aw(ex_aw), .ex_reg_write(ex_reg_write), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(a_pc), .fd_write(a_fd), .fd_flush(a_fdf), .de_write(a_de), .de_bubble(a_deb),
    .em_write(a_em), .mw_bubble(a_mwb), .stall_count(a_sc), .flush_count(a_fc), .mem_error(a_me)
  );

  pipeline_hazard_controller #(.FLUSH_ON_BRANCH(1'b0)) u_b (
    .clk(clk), .reset(reset), .dec_aa(dec_aa), .dec_ab(dec_ab), .dec_uses_aa(dec_uses_aa),
    .dec_uses_ab(dec_uses_ab), .dec_br_taken(dec_br_taken), .ex_mem_read(ex_mem_read),
    .ex_aw(ex_aw), .ex_reg_write(ex_reg_write), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(b_pc), .fd_write(b_fd), .fd_flush(b_fdf), .de_write(b_de), .de_bubble(b_deb),
    .em_write(b_em), .mw_bubble(b_mwb), .stall_count(b_sc), .flush_count(b_fc), .mem_error(b_me)
  );

  pipeline_hazard_controller #(.CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .dec_aa(dec_aa), .dec_ab(dec_ab), .dec_uses_aa(dec_uses_aa),
    .dec_uses_ab(dec_uses_ab), .dec_br_taken(dec_br_taken), .ex_mem_read(ex_mem_read),
    .ex_aw(ex_aw), .ex_reg_write(ex_reg_write), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_write(c_pc), .fd_write(c_fd), .fd_flush(c_fdf), .de_write(c_de), .de_bubble(c_deb),
    .em_write(c_em), .mw_bubble(c_mwb), .stall_count(c_sc), .flush_count(c_fc), .mem_error(c_me)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_memwait();
    return mem_access && !mem_ready;
  endfunction

  function automatic bit f_loaduse();
    bit hit_a, hit_b;
    hit_a = dec_uses_aa && (dec_aa == ex_aw);
    hit_b = dec_uses_ab && (dec_ab == ex_aw);
    return ex_mem_read && ex_reg_write && (ex_aw != 5'd31) && (hit_a || hit_b);
  endfunction

  // Expected {pc_write, fd_write, fd_flush, de_write, de_bubble, em_write, mw_bubble}
  function automatic logic [6:0] exp_ctl(input bit fob);
    if (reset)       return 7'b0010101;
    if (f_memwait()) return 7'b0000001;
    if (!m_in_wait && !m_stalled && f_loaduse()) return 7'b0001110;
    return {2'b11, dec_br_taken && fob && !m_in_wait, 4'b1010};
  endfunction

  function automatic int sat(input int raw, input int width);
    int mx;
    mx = (1 << width) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic step();
    logic [6:0] e1, e0;
    bit         mw;
    e1 = exp_ctl(1'b1);
    e0 = exp_ctl(1'b0);
    mw = f_memwait();
    #1;
    chk("ctl_a", {25'd0, a_pc, a_fd, a_fdf, a_de, a_deb, a_em, a_mwb}, {25'd0, e1});
    chk("ctl_b", {25'd0, b_pc, b_fd, b_fdf, b_de, b_deb, b_em, b_mwb}, {25'd0, e0});
    chk("ctl_c", {25'd0, c_pc, c_fd, c_fdf, c_de, c_deb, c_em, c_mwb}, {25'd0, e1});
    if (m_known) begin
      chk("stall_a", {16'd0, a_sc}, sat(m_stall_raw, 16));
      chk("flush_a", {16'd0, a_fc}, sat(m_flush_raw, 16));
      chk("flush_b", {16'd0, b_fc}, sat(m_flush_raw_nf, 16));
      chk("stall_c", {28'd0, c_sc}, sat(m_stall_raw, 4));
      chk("flush_c", {28'd0, c_fc}, sat(m_flush_raw, 4));
      chk("err_a",   {31'd0, a_me}, {31'd0, m_err});
      chk("err_c",   {31'd0, c_me}, {31'd0, m_err});
    end
    @(posedge clk);
    if (reset) begin
      m_known = 1'b1; m_in_wait = 1'b0; m_stalled = 1'b0; m_err = 1'b0;
      m_wc = 0; m_stall_raw = 0; m_flush_raw = 0; m_flush_raw_nf = 0;
    end else begin
      if (!e1[6]) m_stall_raw++;
      if (e1[4])  m_flush_raw++;
      if (e0[4])  m_flush_raw_nf++;
      m_stalled = (e1 == 7'b0001110);
      m_in_wait = mw;
      m_wc      = mw ? ((m_wc >= 64) ? 64 : m_wc + 1) : 0;
      if (m_wc == 64) m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; dec_aa = 5'd0; dec_ab = 5'd0; ex_aw = 5'd0;
    dec_uses_aa = 1'b0; dec_uses_ab = 1'b0; dec_br_taken = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_access = 1'b0; mem_ready = 1'b1;
  endtask

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    step();
    step();
    idle();
    step();

    // Load-use on register 5 stalls once
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_aw = 5'd5; dec_aa = 5'd5; dec_uses_aa = 1'b1;
    step();
    idle();
    step();
    chk("plan_lu_stall", {16'd0, a_sc}, 32'd1);
    // XZR destination never stalls
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_aw = 5'd31; dec_aa = 5'd31; dec_uses_aa = 1'b1;
    step();
    idle();

    dec_br_taken = 1'b1;
    step();
    idle();
    step();
    chk("plan_br_flush", {16'd0, a_fc}, 32'd1);
    chk("plan_br_noflush", {16'd0, b_fc}, 32'd0);

    // Branch together with load-use: stall wins, branch flushes afterwards
    dec_br_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_aw = 5'd7; dec_ab = 5'd7; dec_uses_ab = 1'b1;
    step();
    ex_mem_read = 1'b0;
    step();
    idle();
    step();

    // Three cycles of memory wait, then release
    mem_access = 1'b1; mem_ready = 1'b0;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    idle();
    step();

    // Timeout: 64 cycles without ready
    mem_access = 1'b1; mem_ready = 1'b0;
    repeat (10) step();
    chk("plan_no_err_early", {31'd0, a_me}, 32'd0);
    repeat (54) step();
    mem_ready = 1'b1;
    step();
    chk("plan_err_set", {31'd0, a_me}, 32'd1);
    chk("plan_sat_c", {28'd0, c_sc}, 32'd15);
    mem_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    idle();
    step();
    chk("plan_err_clear", {31'd0, a_me}, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      ex_aw        = rreg();
      dec_aa       = rreg();
      dec_ab       = rreg();
      dec_uses_aa  = 1'($urandom);
      dec_uses_ab  = 1'($urandom);
      dec_br_taken = ($urandom_range(0, 3) == 0);
      ex_mem_read  = 1'($urandom);
      ex_reg_write = ($urandom_range(0, 3) != 0);
      mem_access   = 1'($urandom);
      mem_ready    = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipelined CPU (Fetch, Dec, Ex, Mem, Wb).
- Drives write enables and bubble/flush controls for the PC and the four pipeline registers, covering:
  - load-use hazards the forwarding unit cannot cover;
  - taken-branch wrong-path flush;
  - multi-cycle data-memory waits.
- Keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count performance counters.
- MEM_TIMEOUT, 64, maximum consecutive WAIT cycles before mem_error sets.
- FLUSH_ON_BRANCH, 1, 1 = flush the Fetch->Dec register on a taken branch; 0 = architectural delay slot, no flush.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- dec_aa  in  5  Dec-stage read register A.
- dec_ab  in  5  Dec-stage read register B.
- dec_uses_aa  in  1  Dec instruction reads dec_aa.
- dec_uses_ab  in  1  Dec instruction reads dec_ab.
- dec_br_taken  in  1  branch resolved taken in Dec this cycle.
- ex_mem_read  in  1  Ex-stage instruction is a load.
- ex_aw  in  5  Ex-stage destination register.
- ex_reg_write  in  1  Ex-stage instruction writes the register file.
- mem_access  in  1  Mem-stage instruction reads or writes data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- fd_write  out  1  Fetch->Dec register enable.
- fd_flush  out  1  load NOP into Fetch->Dec.
- de_write  out  1  Dec->Ex register enable.
- de_bubble  out  1  zero the control fields loaded into Dec->Ex.
- em_write  out  1  Ex->Mem register enable.
- mw_bubble  out  1  zero the control fields loaded into Mem->Wb.
- stall_count  out  CNT_W  cycles spent in STALL or WAIT, saturating.
- flush_count  out  CNT_W  fd_flush pulses, saturating.
- mem_error  out  1  sticky memory-timeout flag.

Behaviour:
- Registered FSM with states RUN, STALL, WAIT. Outputs are combinational from the current state and the inputs. Counters and mem_error are registered.
- Reset is synchronous. While reset is high:
  - pc_write, fd_write, de_write and em_write = 0;
  - fd_flush, de_bubble and mw_bubble = 1.
- On the first edge with reset high: state <= RUN, counters <= 0, wait counter <= 0, mem_error <= 0.
- Reset mid-WAIT or mid-STALL aborts the operation the same way.
- Hazard terms:
  - memwait = mem_access && !mem_ready.
  - loaduse = ex_mem_read && ex_reg_write && ex_aw != 31 && ((dec_uses_aa && dec_aa == ex_aw) || (dec_uses_ab && dec_ab == ex_aw)).
  - Register 31 (XZR) never causes a hazard.
- Priority, highest first: memwait, loaduse, branch.
- RUN, memwait = 1:
  - all four enables 0, mw_bubble = 1, fd_flush = 0, de_bubble = 0;
  - next state WAIT.
- RUN, loaduse = 1 (memwait = 0):
  - pc_write = 0, fd_write = 0, de_bubble = 1, de_write = 1, em_write = 1;
  - fd_flush = 0; dec_br_taken is ignored this cycle because the branch is re-evaluated after the stall;
  - next state STALL.
- RUN otherwise:
  - all enables 1, bubbles 0;
  - fd_flush = dec_br_taken && FLUSH_ON_BRANCH;
  - stays in RUN.
- STALL (exactly one cycle):
  - outputs as RUN, since the Ex stage now holds a bubble and loaduse cannot re-fire from the same load;
  - memwait still has priority (-> WAIT);
  - otherwise returns to RUN.
- WAIT:
  - outputs as in the RUN memwait case while memwait = 1;
  - in the cycle mem_ready = 1: all enables 1, mw_bubble = 0, next state RUN;
  - loaduse and branch are not evaluated in WAIT; they are re-evaluated in RUN on the following cycle.
- Wait counter:
  - increments each WAIT cycle and clears on leaving WAIT;
  - when it reaches MEM_TIMEOUT, mem_error <= 1 and the FSM stays in WAIT;
  - mem_error clears only on reset.
- stall_count increments on every cycle that pc_write = 0 while reset is low. flush_count increments on every fd_flush = 1 while reset is low. Both saturate at 2^CNT_W - 1 with no wrap.
- Simultaneous loaduse and memwait: WAIT is taken first; the loaduse stall is applied after WAIT exits if the hazard is still present.

Test Plan:
- Reset held 2 cycles, then released with idle inputs -> during reset enables = 0 and bubbles = 1; afterwards pc_write = fd_write = de_write = em_write = 1, all counters 0, state RUN.
- ex_mem_read = 1, ex_reg_write = 1, ex_aw = 5, dec_aa = 5, dec_uses_aa = 1 -> one cycle of pc_write = 0, fd_write = 0, de_bubble = 1, stall_count = 1; next cycle back to RUN. Repeat with ex_aw = 31 -> no stall.
- dec_br_taken = 1 in RUN -> fd_flush = 1 for one cycle, flush_count = 1. With FLUSH_ON_BRANCH = 0 -> fd_flush stays 0.
- dec_br_taken = 1 together with loaduse -> fd_flush = 0 and de_bubble = 1; the branch flushes on the next RUN cycle if still taken.
- mem_access = 1 with mem_ready low for 3 cycles, then high -> 3 cycles all enables 0 and mw_bubble = 1, stall_count = 3, release in the mem_ready cycle.
- mem_ready held low 64 cycles -> mem_error = 1 and stays set after mem_ready rises; reset asserted mid-WAIT -> state RUN and mem_error = 0.
- stall_count preloaded near max via 2^CNT_W stalls (CNT_W = 4 build) -> holds at 15 with no wrap.
